// File: rtl/exec_occupancy_tracker.sv
// Execute-stage occupancy model for the level-2 instruction buffer.
// A single non-pipelined execute slot with per-class latency. It reports busy and
// last-busy-cycle status back to the buffer and emits a tagged retire pulse.
// Optional performance counters are enabled by defining EXEC_PERF_CNT_EN.

module exec_occupancy_tracker #(
    parameter int unsigned SHORT_LAT = 1,
    parameter int unsigned LONG_LAT  = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              issue_valid,
    input  logic                              issue_is_long,
    input  logic [TAG_W-1:0]                  issue_tag,
    input  logic                              flush,
    output logic                              exec_busy,
    output logic                              exec_will_free_next,
    output logic                              retire_valid,
    output logic [TAG_W-1:0]                  retire_tag,
    output logic                              issue_err,
    output logic [$clog2(LONG_LAT+1)-1:0]     remaining
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_busy_cycles,
    output logic [31:0]                       perf_retired
`endif
);

    localparam int unsigned RemW = $clog2(LONG_LAT + 1);

    // LONG_LAT fits in RemW bits by construction, and SHORT_LAT <= LONG_LAT.
    localparam logic [RemW-1:0] ShortLatW = RemW'(SHORT_LAT);
    localparam logic [RemW-1:0] LongLatW  = RemW'(LONG_LAT);
    localparam logic [RemW-1:0] OneW      = RemW'(1);

    logic [RemW-1:0]  remaining_q, remaining_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             retire_valid_q, retire_valid_d;
    logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
    logic             issue_err_q, issue_err_d;
    logic             can_accept;
    logic             accept;

    // Status is derived only from registered state, so the buffer sees no input paths.
    always_comb begin
        exec_busy           = (remaining_q != '0);
        exec_will_free_next = (remaining_q == OneW);
        can_accept          = ~exec_busy | exec_will_free_next;
        accept              = issue_valid & can_accept & ~flush;
    end

    // Next-state: flush wins, then accept (may overlap the last busy cycle), then countdown.
    always_comb begin
        remaining_d    = remaining_q;
        tag_d          = tag_q;
        retire_valid_d = 1'b0;
        retire_tag_d   = retire_tag_q;
        issue_err_d    = issue_err_q;

        if (flush) begin
            remaining_d = '0;
        end else if (accept) begin
            remaining_d = issue_is_long ? LongLatW : ShortLatW;
            tag_d       = issue_tag;
        end else if (remaining_q != '0) begin
            remaining_d = remaining_q - OneW;
        end

        // The old instruction still completes when a new one is accepted on its last cycle.
        if (exec_will_free_next && !flush) begin
            retire_valid_d = 1'b1;
            retire_tag_d   = tag_q;
        end

        if (issue_valid && !can_accept && !flush) begin
            issue_err_d = 1'b1;
        end
    end

    // Slot state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q    <= '0;
            tag_q          <= '0;
            retire_valid_q <= 1'b0;
            retire_tag_q   <= '0;
            issue_err_q    <= 1'b0;
        end else begin
            remaining_q    <= remaining_d;
            tag_q          <= tag_d;
            retire_valid_q <= retire_valid_d;
            retire_tag_q   <= retire_tag_d;
            issue_err_q    <= issue_err_d;
        end
    end

    // Drive the registered outputs.
    always_comb begin
        remaining    = remaining_q;
        retire_valid = retire_valid_q;
        retire_tag   = retire_tag_q;
        issue_err    = issue_err_q;
    end

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_retired_q;

    // Free-running counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_busy_q    <= '0;
            perf_retired_q <= '0;
        end else begin
            if (exec_busy) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (retire_valid_q) begin
                perf_retired_q <= perf_retired_q + 32'd1;
            end
        end
    end

    // Drive the counter outputs.
    always_comb begin
        perf_busy_cycles = perf_busy_q;
        perf_retired     = perf_retired_q;
    end
`endif

endmodule
